// File: rtl/f1_pkg.sv
// f1_pkg: shared state type, constants and LFSR step for the F1 start-light sequencer and reaction timer
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEQ,
        HOLD,
        GO,
        DONE,
        FAULT
    } f1_rt_state_t;

    localparam logic [7:0] LIGHTS_ALL_ON = 8'hFF;
    localparam logic [6:0] LFSR_SEED     = 7'h01;

    // Fibonacci step for x^7 + x^3 + 1; a non-zero state never reaches zero
    function automatic logic [6:0] lfsr7_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[2]};
    endfunction

endpackage

// File: rtl/f1_lfsr7.sv
// f1_lfsr7: free-running 7-bit maximal-length LFSR, reloaded with LFSR_SEED on rst
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   out : current LFSR state
module f1_lfsr7
    import f1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] out
);

    always_ff @(posedge clk)
        out <= rst ? LFSR_SEED : lfsr7_next(out);

endmodule

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: gates the start-light sequencer, holds all lights for a random delay, then times the driver's reaction
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   tick          : 1 ms time-base pulse
//   trigger       : debounced driver button (level)
//   lights_in     : pattern from the sequencer
//   lights_en     : sequencer step enable
//   lights_out    : pattern shown on the display
//   react_ms      : last reaction time in ticks
//   result_valid  : react_ms holds a fresh result
//   jump_start    : driver pressed before lights-out
module f1_reaction_timer
    import f1_pkg::*;
#(
    parameter int MIN_DELAY_MS = 200,
    parameter int DELAY_SHIFT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        trigger,
    input  logic [7:0]  lights_in,
    output logic        lights_en,
    output logic [7:0]  lights_out,
    output logic [15:0] react_ms,
    output logic        result_valid,
    output logic        jump_start
);

    f1_rt_state_t state;
    logic         trig_q;
    logic         trig_edge;
    logic         hold_exit;
    logic [6:0]   lfsr;
    logic [15:0]  delay_cnt;
    logic [15:0]  delay_load;
    logic [15:0]  rt_cnt;

    f1_lfsr7 u_lfsr (
        .clk(clk),
        .rst(rst),
        .out(lfsr)
    );

    assign trig_edge  = trigger & ~trig_q;
    assign hold_exit  = trig_edge | (delay_cnt == '0);
    assign delay_load = 16'(MIN_DELAY_MS) + (16'(lfsr) << DELAY_SHIFT);

    // Leaving HOLD pulses lights_en once so the sequencer wraps from 0xFF back to 0x00
    always_comb begin
        lights_en  = (state == SEQ) ? tick : (state == HOLD) ? hold_exit : 1'b0;
        lights_out = (state == SEQ || state == HOLD) ? lights_in : 8'h00;
    end

    assign result_valid = (state == DONE);
    assign jump_start   = (state == FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            delay_cnt <= '0;
            rt_cnt    <= '0;
            react_ms  <= '0;
        end else begin
            trig_q <= trigger;
            case (state)
                IDLE:  if (trig_edge) state <= SEQ;
                SEQ:   if (lights_in == LIGHTS_ALL_ON) begin
                           state     <= HOLD;
                           delay_cnt <= delay_load;
                       end
                // A press wins over expiry in the same cycle
                HOLD:  if (trig_edge) state <= FAULT;
                       else if (delay_cnt == '0) begin
                           state  <= GO;
                           rt_cnt <= '0;
                       end else if (tick) delay_cnt <= delay_cnt - 16'd1;
                // A tick coinciding with the press is not counted
                GO:    if (trig_edge) begin
                           state    <= DONE;
                           react_ms <= rt_cnt;
                       end else if (tick && rt_cnt != 16'hFFFF) rt_cnt <= rt_cnt + 16'd1;
                DONE:  if (trig_edge) state <= SEQ;
                FAULT: if (trig_edge) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer: directed run sequence with randomized timing, checked against a tick-counting reference model
module tb_f1_reaction_timer;

    localparam int MIN_D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        trigger = 1'b0;
    logic [7:0]  lights_in;
    logic        lights_en;
    logic [7:0]  lights_out;
    logic [15:0] react_ms;
    logic        result_valid;
    logic        jump_start;

    logic [7:0]  seq_q = 8'h00;
    logic [6:0]  tab [127];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          k = 0;
    bit          fast = 1'b0;
    int          exp_react = 0;

    f1_reaction_timer #(
        .MIN_DELAY_MS(MIN_D),
        .DELAY_SHIFT(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .trigger(trigger),
        .lights_in(lights_in),
        .lights_en(lights_en),
        .lights_out(lights_out),
        .react_ms(react_ms),
        .result_valid(result_valid),
        .jump_start(jump_start)
    );

    always #5 clk = ~clk;

    // Stand-in start-light sequencer: one more light per enable, wrapping to dark after all eight
    always @(posedge clk)
        seq_q <= rst ? 8'h00 : !lights_en ? seq_q : (seq_q == 8'hFF) ? 8'h00 : {seq_q[6:0], 1'b1};
    assign lights_in = seq_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change just after the rising edge, checks happen at the falling edge
    task automatic step(input logic trg);
        @(posedge clk);
        k = rst ? 0 : k + 1;
        #1;
        cyc++;
        tick = fast || (cyc % 4 == 0);
        trigger = trg;
        @(negedge clk);
    endtask

    task automatic run_to_hold(output int d);
        int pulses = 0;
        bit found = 1'b0;
        d = MIN_D;
        for (int i = 0; i < 200 && !found; i++) begin
            chk("seq_en", lights_en, tick);
            chk("seq_out", lights_out, lights_in);
            if (lights_in == 8'hFF) begin
                found = 1'b1;
                d = MIN_D + int'(tab[k % 127]);
            end else begin
                pulses += int'(lights_en);
                step(1'b0);
            end
        end
        chk("seq_found", found, 1);
        chk("seq_pulses", pulses, 8);
        step(1'b0);
    endtask

    // mode 0: wait for lights-out, 1: press after pk ticks, 2: press in the expiry cycle
    task automatic hold(input int d, input int mode, input int pk);
        int seen = 0;
        bit zero;
        bit trg;
        bit done = 1'b0;
        bit fault = 1'b0;
        for (int i = 0; i < 4 * d + 20 && !done; i++) begin
            zero = (seen == d);
            chk("hold_out", lights_out, 8'hFF);
            chk("hold_en", lights_en, zero | trigger);
            if (zero | trigger) begin
                done = 1'b1;
                fault = trigger;
            end else begin
                seen += int'(tick);
                trg = (mode == 2) ? (seen == d) : (mode == 1) && tick && (seen == pk);
                step(trg);
            end
        end
        chk("hold_done", done, 1);
        chk("hold_exit", fault, mode != 0);
        step(1'b0);
    endtask

    task automatic go(input int target, input bit keep, input int extra);
        int n = 0;
        int x;
        bit done = 1'b0;
        x = extra;
        fast = target > 1000;
        for (int i = 0; i < target * 4 + 100 && !done; i++) begin
            chk("go_out", lights_out, 8'h00);
            chk("go_en", lights_en, 0);
            chk("go_valid", result_valid, 0);
            if (trigger) done = 1'b1;
            else begin
                n += int'(tick);
                if (n >= target) x--;
                step(n >= target && x < 0);
            end
        end
        chk("go_done", done, 1);
        exp_react = (n > 65535) ? 65535 : n;
        fast = 1'b0;
        step(keep);
        chk("done_valid", result_valid, 1);
        chk("done_react", react_ms, exp_react);
        chk("done_jump", jump_start, 0);
        chk("done_out", lights_out, 8'h00);
        chk("done_en", lights_en, 0);
    endtask

    task automatic restart_from_done();
        step(1'b1);
        chk("done_press_valid", result_valid, 1);
        step(1'b0);
        chk("seq_valid", result_valid, 0);
        chk("seq_react", react_ms, exp_react);
    endtask

    task automatic check_fault();
        chk("fault_jump", jump_start, 1);
        chk("fault_out", lights_out, 8'h00);
        chk("fault_en", lights_en, 0);
        chk("fault_valid", result_valid, 0);
        step(1'b0);
        chk("fault_jump2", jump_start, 1);
        step(1'b1);
        step(1'b0);
        chk("idle_jump", jump_start, 0);
        for (int i = 0; i < 6; i++) begin
            chk("idle_en", lights_en, 0);
            chk("idle_out", lights_out, 8'h00);
            step(1'b0);
        end
    endtask

    initial begin
        logic [6:0] v;
        int d;
        v = 7'h01;
        for (int i = 0; i < 127; i++) begin
            tab[i] = v;
            v = {v[5:0], v[6] ^ v[2]};
        end
        rst = 1'b1;
        repeat (3) step(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            chk("rst_en", lights_en, 0);
            chk("rst_out", lights_out, 8'h00);
        end
        chk("rst_react", react_ms, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_jump", jump_start, 0);

        // Full run, 25-tick reaction
        repeat ($urandom_range(0, 40)) step(1'b0);
        step(1'b1);
        chk("idle_press_en", lights_en, 0);
        step(1'b0);
        run_to_hold(d);
        hold(d, 0, 0);
        go(25, 1'b0, 0);
        for (int i = 0; i < int'($urandom_range(2, 8)); i++) begin
            step(1'b0);
            chk("done_stay_valid", result_valid, 1);
            chk("done_stay_react", react_ms, 25);
        end
        restart_from_done();

        // Jump start part-way through the hold
        run_to_hold(d);
        hold(d, 1, int'($urandom_range(1, d - 1)));
        check_fault();

        // Trigger held across GO->DONE counts once; release and re-press restarts
        step(1'b1);
        step(1'b0);
        run_to_hold(d);
        hold(d, 0, 0);
        go(int'($urandom_range(1, 60)), 1'b1, int'($urandom_range(0, 5)));
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            chk("held_valid", result_valid, 1);
            chk("held_react", react_ms, exp_react);
        end
        step(1'b0);
        step(1'b0);
        restart_from_done();

        // Press in the very cycle the hold expires: jump start wins
        run_to_hold(d);
        hold(d, 2, 0);
        check_fault();

        // Reaction counter saturates
        step(1'b1);
        step(1'b0);
        run_to_hold(d);
        hold(d, 0, 0);
        go(70000, 1'b0, int'($urandom_range(0, 5)));
        chk("sat_react", react_ms, 16'hFFFF);
        restart_from_done();

        // Reset in the middle of GO
        run_to_hold(d);
        hold(d, 0, 0);
        for (int i = 0; i < int'($urandom_range(3, 20)); i++) begin
            chk("go_wait_out", lights_out, 8'h00);
            step(1'b0);
        end
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        exp_react = 0;
        chk("mid_rst_react", react_ms, 0);
        chk("mid_rst_out", lights_out, 8'h00);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_jump", jump_start, 0);
        chk("mid_rst_en", lights_en, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            chk("post_rst_en", lights_en, 0);
        end

        // One more random run after the reset
        step(1'b1);
        step(1'b0);
        run_to_hold(d);
        hold(d, 0, 0);
        go(int'($urandom_range(1, 60)), 1'b0, int'($urandom_range(0, 5)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
